// File: rtl/clock_div_multi_pkg.sv
// clock_div_multi_pkg: shared widths and constant helpers for the multi-channel clock divider
package clock_div_multi_pkg;
  localparam int CNT_W_DEF = 32;
  function automatic int unsigned half_from_ms(int unsigned freq, int unsigned ms);
    return freq / 2000 * ms;
  endfunction
  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clock_div_chan.sv
// clock_div_chan: one divider channel; ports clk/rst_n, en_i, clr_i, we_i/half_i (shadow write), clk_o, tick_o, pend_o
module clock_div_chan #(
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEF = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic clk_q, clk_d, tick_q, tick_d, pend_q, pend_d;
  logic wrap, stop, apply;
  // stop and wrap are both safe points to swap in the shadow half-period
  always_comb begin
    wrap = cnt_q == act_q;
    stop = clr_i | ~en_i;
    apply = stop | wrap;
    cnt_d = apply ? '0 : cnt_q + CNT_W'(1);
    clk_d = stop ? 1'b0 : (wrap ? ~clk_q : clk_q);
    tick_d = ~stop & wrap & ~clk_q;
    act_d = (apply & pend_q) ? shd_q : act_q;
    shd_d = we_i ? half_i : shd_q;
    pend_d = we_i | (pend_q & ~apply);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
      act_q <= DEF;
      shd_q <= DEF;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      act_q <= act_d;
      shd_q <= shd_d;
    end
  end
  assign clk_o = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/clock_div_multi.sv
// clock_div_multi: NUM_CH programmable square-wave dividers; ports clk/rst_n, en, sync_clr, cfg_we/cfg_ch/cfg_half, clk_out, tick, cfg_pend
module clock_div_multi
  import clock_div_multi_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned PERIOD_MS = 10,
  parameter int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
);
  localparam logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(half_from_ms(CLK_FREQ_HZ, PERIOD_MS));
  // an out-of-range cfg_ch matches no channel, so the write is dropped
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_chan #(.CNT_W(CNT_W), .DEF(DEFAULT_HALF)) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .en_i(en[g]),
      .clr_i(sync_clr),
      .we_i(cfg_we && cfg_ch == CH_W'(g)),
      .half_i(cfg_half),
      .clk_o(clk_out[g]),
      .tick_o(tick[g]),
      .pend_o(cfg_pend[g])
    );
  end
endmodule
